zed_out_arbiter: RTL
====================

# zed_out_arbiter

Round-robin arbiter that shares the chip's single 8-bit output port (`uo_out`) among up to 8 internal byte-stream requesters inside `tt_um_zedtc1_top`. Grants the port to one requester at a time for a burst that ends on `last`, on a beat limit, or on an idle timeout. Registers the outgoing byte and tags it with its owner index. The consumer acknowledges each byte with a one-cycle strobe.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 4: maximum beats per grant, 1..15.
- `TIMEOUT`, 8: idle cycles before a stalled owner loses its grant, 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; when low, no new grants are made and no new beats are accepted.
- `req_valid`  in  NREQ  requester i has a byte on its data lane.
- `req_last`  in  NREQ  requester i's current byte ends its burst.
- `req_data`  in  8*NREQ  byte lanes; lane i is bits [8i+7:8i].
- `req_ready`  out  NREQ  beat accepted from requester i this cycle (`valid & ready`).
- `out_data`  out  8  registered output byte.
- `out_valid`  out  1  `out_data` holds an unacknowledged byte.
- `out_owner`  out  3  index of the requester that supplied `out_data`.
- `out_ack`  in  1  consumer takes `out_data` this cycle; ignored while `out_valid` is 0.

## Operation
- States: IDLE, BUSY.
- **IDLE**
  - If `ena` and any `req_valid` is set: select the first set bit scanning upward from `last_grant+1` (mod NREQ).
  - Latch the selection into `owner` and `last_grant`, clear `beat_cnt` and `idle_cnt`, go to BUSY.
  - `req_ready` is all zero.
- **BUSY**
  - `req_ready[owner] = ena & req_valid[owner] & (!out_valid | out_ack)`; all other bits are 0.
  - On an accepted beat:
    - `out_data <= lane[owner]`, `out_owner <= owner`, `out_valid <= 1`.
    - `beat_cnt` increments and `idle_cnt` clears.
    - If `req_last[owner]` or `beat_cnt+1 == MAX_BURST`, go to IDLE.
  - No beat and `req_valid[owner]` is 0: `idle_cnt` increments. When `idle_cnt+1 == TIMEOUT`, go to IDLE (grant lost; the owner must re-arbitrate).
  - `req_valid[owner]` high but blocked by the output register or by `ena` low: `idle_cnt` holds. Backpressure never times out.
- **Output register**
  - `out_ack & out_valid` with no new beat clears `out_valid`.
  - An ack and a new beat in the same cycle keep `out_valid` at 1 and load the new byte (back-to-back, no bubble).
  - Draining continues regardless of state or `ena`.
- `ena` low in BUSY: grant is held, no beats are accepted, timeout counter holds.
- Requester indices ≥ NREQ never exist; `out_owner` is zero-extended to 3 bits.
- **Reset (async, any time)**
  - State IDLE; `out_data` = 0x00, `out_valid` = 0, `out_owner` = 0, `req_ready` = 0.
  - `last_grant` = NREQ-1, so the first grant scan starts at requester 0.
  - Counters = 0.
  - A burst in flight is discarded; no partial state survives.

## Timing
- The grant decision is registered. A requester raising `req_valid` at cycle 0 in IDLE is in BUSY at cycle 1, has `req_ready` high at cycle 1, and sees `out_valid` high at cycle 2.
- Sustained throughput with `out_ack` held high is 1 byte/cycle within a burst.
- Each grant costs one IDLE cycle, so an N-beat burst occupies N+1 cycles.
- `req_ready` is combinational from state, `out_valid`, `out_ack`, `ena` and `req_valid`. There is no combinational path from `req_data` to any output.
- `out_*` change only on the `clk` rising edge or on reset assertion.

## Test plan
- **Reset defaults:** assert `rst_n`=0 mid-burst -> all outputs 0 immediately. After release, requesters 0 and 2 valid -> requester 0 is granted first.
- **Round-robin:** requesters 0..3 all valid with single-beat `last` bursts, `out_ack`=1 -> `out_owner` sequence 0,1,2,3,0; each byte 2 cycles apart.
- **Beat limit:** requester 1 streams 0x10..0x19 with no `last`, MAX_BURST=4 -> 0x10..0x13 delivered, grant released; requester 2 (waiting) is served next; requester 1 resumes at 0x14.
- **Backpressure:** `out_ack`=0 for 5 cycles during a burst -> `out_valid`=1, `out_data` stable, `req_ready`=0, no timeout. Then `out_ack`=1 -> one byte per cycle with no bubble.
- **Timeout:** owner 3 drops `req_valid` after 1 beat, TIMEOUT=8 -> BUSY for 8 idle cycles, then IDLE; requester 0 is granted on the next cycle.
- **ena gating:** `ena`=0 with requesters valid -> no grant, `req_ready`=0, and a pending `out_data` still drains on `out_ack`. Raising `ena` resumes arbitration.

Source files
------------

// File: rtl/zed_out_arbiter.sv
// zed_out_arbiter
//
// Round-robin arbiter that shares the chip's single 8-bit output port among
// up to 8 internal byte-stream requesters. One requester owns the port at a
// time for a burst. The burst ends on its last beat, on the beat limit, or
// after the owner has been idle for too long. Every accepted byte is
// registered and tagged with the index of the requester that sent it. The
// consumer acknowledges each byte with a one-cycle strobe.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   MAX_BURST  maximum beats per grant (1..15)
//   TIMEOUT    idle cycles before a stalled owner loses its grant (1..15)
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   ena_i        design enable; low blocks new grants and new beats
//   req_valid_i  per-requester byte valid
//   req_last_i   per-requester end-of-burst marker
//   req_data_i   byte lanes, lane i is bits [8i+7:8i]
//   req_ready_o  per-requester beat-accepted strobe (valid & ready)
//   out_data_o   registered output byte
//   out_valid_o  out_data_o holds an unacknowledged byte
//   out_owner_o  index of the requester that supplied out_data_o
//   out_ack_i    consumer takes out_data_o this cycle
module zed_out_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_last_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  output logic [2:0]        out_owner_o,
  input  logic              out_ack_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  out_owner_q, out_owner_d;

  // Requester vectors padded to the full 3-bit index space, so that
  // indexing with owner or scan indices never selects past the vector.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic        owner_valid;
  logic        owner_last;
  logic [7:0]  lane_data;

  logic [3:0]  cand;
  logic        grant_found;
  logic [2:0]  grant_idx;
  logic        accept;

  always_comb begin
    valid_pad = '0;
    last_pad  = '0;
    valid_pad[NREQ-1:0] = req_valid_i;
    last_pad[NREQ-1:0]  = req_last_i;
  end

  assign owner_valid = valid_pad[owner_q];
  assign owner_last  = last_pad[owner_q];

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        lane_data = req_data_i[8*i +: 8];
      end
    end
  end

  // Scan upward from the requester after the last grant, wrapping mod NREQ.
  // The candidate index is kept one bit wider so the wrap can be detected
  // before it is reduced back into range.
  always_comb begin
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 4'(last_grant_q) + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!grant_found && valid_pad[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // A beat moves only when the output register is empty or being drained
  // in the same cycle, which gives back-to-back transfers under a held ack.
  assign accept = (state_q == BUSY) && ena_i && owner_valid &&
                  (!out_valid_q || out_ack_i);

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = accept && (owner_q == 3'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_owner_d  = out_owner_q;

    // The output register drains independently of state and enable.
    if (out_valid_q && out_ack_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ena_i && grant_found) begin
          state_d      = BUSY;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          beat_cnt_d   = '0;
          idle_cnt_d   = '0;
        end
      end
      BUSY: begin
        if (accept) begin
          out_data_d  = lane_data;
          out_owner_d = owner_q;
          out_valid_d = 1'b1;
          beat_cnt_d  = beat_cnt_q + 4'd1;
          idle_cnt_d  = '0;
          if (owner_last || (beat_cnt_q + 4'd1 == 4'(MAX_BURST))) begin
            state_d = IDLE;
          end
        end else if (ena_i && !owner_valid) begin
          // Only a silent owner ages; a blocked owner (backpressure or
          // enable low) keeps its grant indefinitely.
          idle_cnt_d = idle_cnt_q + 4'd1;
          if (idle_cnt_q + 4'd1 == 4'(TIMEOUT)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= 3'(NREQ - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_owner_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_owner_q  <= out_owner_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_owner_o = out_owner_q;

endmodule
